ppm_encoder: RTL and testbench
==============================

PPM_ENCODER -- requirements
Module: ppm_encoder

Interface
REQ-001 SHALL have parameter SLOT_DIV, default 16, giving clk cycles per PPM slot (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, the byte to transmit.
REQ-005 SHALL have port tx_vld, input, 1, tx_data/tx_last valid.
REQ-006 SHALL have port tx_last, input, 1, the byte is the last of its frame.
REQ-007 SHALL have port tx_rdy, output, 1, the holding register can accept a byte.
REQ-008 SHALL have port Dout, output, 1, serial 1-of-4 PPM line (idle high, pulse = low).
REQ-009 SHALL have port busy, output, 1, a frame is in progress (SOF through EOF).
REQ-010 SHALL have port underrun, output, 1, one-cycle pulse when the frame is aborted for lack of data.

Function
REQ-011 SHALL transfer a byte on any cycle with tx_vld=1 and tx_rdy=1 into a one-entry holding register; tx_rdy=1 exactly when the register is empty.
REQ-012 SHALL use FSM states IDLE, SOF, DATA, EOF; slot counter 0..7, divider 0..SLOT_DIV-1, pair index 0..3.
REQ-013 SHALL, in IDLE with the register full, enter SOF on the next cycle; the SOF slot 0 level appears on Dout that same cycle.
REQ-014 SHALL emit SOF as 8 slots with levels 0,1,1,1,0,1,1,1 (slot 0 first).
REQ-015 SHALL encode each byte as 4 symbols of 8 slots, bit pairs LSB first ([1:0],[3:2],[5:4],[7:6]); pair value v drives Dout low only in slot 2v+1.
REQ-016 SHALL move the held byte into the shift register at the start of its first symbol, freeing the holding register (tx_rdy rises the next cycle).
REQ-017 SHALL, at the end of a byte's last symbol, start the next byte with no gap if the register is full and the finished byte had tx_last=0.
REQ-018 SHALL, after a byte with tx_last=1, emit EOF: 4 slots with levels 1,1,0,1, then return to IDLE with Dout=1.
REQ-019 SHALL, if a byte with tx_last=0 ends and the register is empty, pulse underrun for one cycle and emit EOF.
REQ-020 SHALL keep tx_rdy driven per REQ-011 in every state, so the next frame's first byte may be loaded during EOF; the new SOF starts the cycle after EOF ends.
REQ-021 SHALL hold busy=1 from the first SOF cycle through the last EOF cycle, and busy=0 in IDLE.
REQ-022 SHALL make each slot exactly SLOT_DIV cycles and every symbol exactly 8*SLOT_DIV cycles, with no extra cycles at state boundaries.
REQ-023 SHALL drive Dout from a register (glitch-free).

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, all counters 0, holding register empty, Dout=1, busy=0, underrun=0, tx_rdy=0.
REQ-025 SHALL raise tx_rdy on the first clk edge after rst_n deasserts.
REQ-026 SHALL, on reset mid-frame, drop the frame immediately with no EOF; the line returns high asynchronously.

Structure
REQ-027 SHALL take the following from shared package ppm_pkg: the state enum, SLOTS_PER_SYM=8, SOF_PATTERN=8'b1110_1110 (slot 0 at the LSB, level per bit) and EOF_PATTERN=4'b1011 (slot 0 at the LSB); the decoder shares this package.
REQ-028 SHALL place the slot-tick divider in one sub-module ppm_slot_tick (clk, rst_n, restart, tick).

Verification
REQ-029 Single byte 0xE4 with tx_last=1, SLOT_DIV=16 -> SOF, then pulses in slots 1,3,5,7 of successive symbols, then EOF; busy high for exactly 704 cycles.
REQ-030 Bytes 0x00 and 0xFF back-to-back, second with tx_last=1 -> 8 symbols with no gap; pulses all in slot 1, then all in slot 7; a single SOF and a single EOF.
REQ-031 Byte 0x1B with tx_last=0 and no follow-up byte -> underrun pulses once at the end of the byte, then EOF; busy falls 64 cycles later.
REQ-032 tx_vld held high throughout -> tx_rdy low while the register is full; no byte is lost or duplicated over a 16-byte frame (checked by the reference decoder model).
REQ-033 rst_n pulsed low in mid-symbol -> Dout=1 and busy=0 asynchronously; tx_rdy=1 one cycle after release; the next frame is encoded correctly.
REQ-034 Next frame's byte loaded during EOF -> the new SOF starts exactly one slot boundary after the EOF ends, with no gap cycle.

Source files
------------

// File: rtl/ppm_pkg.sv
`default_nettype none
// ppm_pkg: framing constants, FSM state type and slot-level helper shared by PPM encoder and decoder.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    DATA = 2'd2,
    EOF  = 2'd3
  } ppm_state_t;

  localparam int         SLOTS_PER_SYM = 8;
  localparam logic [7:0] SOF_PATTERN   = 8'b1110_1110;
  localparam logic [3:0] EOF_PATTERN   = 4'b1011;

  // Line level for one data slot: bit pair v pulls the line low only in slot 2v+1.
  function automatic logic data_level(input logic [7:0] b, input logic [1:0] pair,
                                      input logic [2:0] slot);
    logic [1:0] v;
    v = b[{pair, 1'b0} +: 2];
    return !(slot == {v, 1'b1});
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppm_slot_tick.sv
`default_nettype none
// ppm_slot_tick: free-running slot divider, tick on the last clk of each SLOT_DIV-cycle slot.
module ppm_slot_tick #(
  parameter int SLOT_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] c_last = 8'(SLOT_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (restart || (r_cnt == c_last)) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign tick = !restart && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ppm_encoder.sv
`default_nettype none
// ppm_encoder: byte-stream to 1-of-4 PPM line encoder with SOF/EOF framing.
module ppm_encoder
  import ppm_pkg::*;
#(
  parameter int SLOT_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  input  logic       tx_last,
  output logic       tx_rdy,
  output logic       Dout,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] c_slot_last = 3'(SLOTS_PER_SYM - 1);

  ppm_state_t r_state, w_state_nxt;
  logic [2:0] r_slot, w_slot_nxt;
  logic [1:0] r_pair, w_pair_nxt;
  logic [7:0] r_byte, w_byte_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_hold_data;
  logic       r_hold_last;
  logic       r_hold_full, w_hold_full_nxt;
  logic       r_rdy;
  logic       r_dout, w_dout_nxt;
  logic       r_busy;
  logic       r_underrun, w_underrun_nxt;
  logic       w_consume;
  logic       w_accept;
  logic       w_restart;
  logic       w_tick;

  ppm_slot_tick #(.SLOT_DIV(SLOT_DIV)) u_slot_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(w_restart),
    .tick   (w_tick)
  );

  assign w_restart = (r_state == IDLE);
  assign w_accept  = tx_vld && r_rdy;
  // Accept needs an empty register and consume a full one, so they never coincide.
  assign w_hold_full_nxt = w_consume ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    w_pair_nxt     = r_pair;
    w_byte_nxt     = r_byte;
    w_last_nxt     = r_last;
    w_consume      = 1'b0;
    w_underrun_nxt = 1'b0;
    w_dout_nxt     = 1'b1;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = SOF;
          w_slot_nxt  = 3'd0;
        end
      end
      SOF: begin
        if (w_tick) begin
          if (r_slot == c_slot_last) begin
            w_state_nxt = DATA;
            w_slot_nxt  = 3'd0;
            w_pair_nxt  = 2'd0;
            w_byte_nxt  = r_hold_data;
            w_last_nxt  = r_hold_last;
            w_consume   = 1'b1;
          end else begin
            w_slot_nxt = r_slot + 3'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_slot != c_slot_last) begin
            w_slot_nxt = r_slot + 3'd1;
          end else begin
            w_slot_nxt = 3'd0;
            if (r_pair != 2'd3) begin
              w_pair_nxt = r_pair + 2'd1;
            end else if (!r_last && r_hold_full) begin
              w_pair_nxt = 2'd0;
              w_byte_nxt = r_hold_data;
              w_last_nxt = r_hold_last;
              w_consume  = 1'b1;
            end else begin
              w_state_nxt    = EOF;
              w_underrun_nxt = !r_last;
            end
          end
        end
      end
      EOF: begin
        if (w_tick) begin
          if (r_slot == 3'd3) begin
            w_slot_nxt  = 3'd0;
            w_state_nxt = r_hold_full ? SOF : IDLE;
          end else begin
            w_slot_nxt = r_slot + 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Line level is computed from the next-cycle view so Dout changes on the same edge as the FSM.
    case (w_state_nxt)
      SOF:     w_dout_nxt = SOF_PATTERN[w_slot_nxt];
      DATA:    w_dout_nxt = data_level(w_byte_nxt, w_pair_nxt, w_slot_nxt);
      EOF:     w_dout_nxt = EOF_PATTERN[w_slot_nxt[1:0]];
      default: w_dout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_slot      <= 3'd0;
      r_pair      <= 2'd0;
      r_byte      <= 8'd0;
      r_last      <= 1'b0;
      r_hold_data <= 8'd0;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
      r_rdy       <= 1'b0;
      r_dout      <= 1'b1;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_pair      <= w_pair_nxt;
      r_byte      <= w_byte_nxt;
      r_last      <= w_last_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_rdy       <= !w_hold_full_nxt;
      r_dout      <= w_dout_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_underrun  <= w_underrun_nxt;
      if (w_accept) begin
        r_hold_data <= tx_data;
        r_hold_last <= tx_last;
      end
    end
  end

  assign tx_rdy   = r_rdy;
  assign Dout     = r_dout;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ppm_encoder.sv
`default_nettype none
// tb_ppm_encoder: directed table-driven bench for ppm_encoder with line capture and PPM decoder model.
module tb_ppm_encoder;

  localparam int SD = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_last;
  logic       tx_rdy;
  logic       Dout;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         p0, p1, p2, p3;
  } vec_t;

  vec_t tbl [7];

  logic       lv_q  [$];
  logic       exp_q [$];
  logic [7:0] snd_d [$];
  logic       snd_l [$];
  int cap_busy, cap_uf, cap_uf_at, cap_shape;

  ppm_encoder #(.SLOT_DIV(SD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_vld  (tx_vld),
    .tx_last (tx_last),
    .tx_rdy  (tx_rdy),
    .Dout    (Dout),
    .busy    (busy),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void exp_sof();
    int lv [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
    for (int s = 0; s < 8; s++) exp_q.push_back(1'(lv[s]));
  endfunction

  function automatic void exp_eof();
    int lv [4] = '{1, 1, 0, 1};
    for (int s = 0; s < 4; s++) exp_q.push_back(1'(lv[s]));
  endfunction

  function automatic void exp_sym(input int p);
    for (int s = 0; s < 8; s++) exp_q.push_back(s != p);
  endfunction

  task automatic cmp_levels(input string name);
    int bad;
    bad = -1;
    chk({name, "_slots"}, lv_q.size(), exp_q.size());
    if (lv_q.size() == exp_q.size()) begin
      checks++;
      foreach (exp_q[i]) if (lv_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_levels: slot %0d got %b expected %b", name, bad, lv_q[bad], exp_q[bad]);
      end
    end
  endtask

  // Presents each queued byte and waits for the handshake; vld stays high between bytes if hold_vld.
  task automatic drive_seq(input bit hold_vld);
    int w;
    @(negedge clk);
    for (int i = 0; i < snd_d.size(); i++) begin
      tx_vld  = 1'b1;
      tx_data = snd_d[i];
      tx_last = snd_l[i];
      w = 0;
      while (!tx_rdy && w < 20000) begin
        @(negedge clk);
        w++;
      end
      if (!tx_rdy) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: byte %0d got no tx_rdy required within 20000 cycles", i);
        break;
      end
      @(negedge clk);
      chk("rdy_low_when_full", int'(tx_rdy), 0);
      if (!hold_vld) begin
        tx_vld = 1'b0;
        @(negedge clk);
      end
    end
    tx_vld  = 1'b0;
    tx_last = 1'b0;
  endtask

  // Records one level per slot for the whole busy period, counting any intra-slot level change.
  task automatic capture();
    int c, w;
    lv_q.delete();
    cap_busy = 0; cap_uf = 0; cap_uf_at = -1; cap_shape = 0;
    w = 0;
    @(negedge clk);
    while (!busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("busy_rise_seen", int'(busy), 1);
    c = 0;
    while (busy && c < 20000) begin
      if (c % SD == 0) lv_q.push_back(Dout);
      else if (Dout !== lv_q[$]) cap_shape++;
      if (underrun) begin
        cap_uf++;
        cap_uf_at = c;
      end
      c++;
      @(negedge clk);
    end
    cap_busy = c;
    chk("idle_line_high", int'(Dout), 1);
  endtask

  task automatic run_vec(input int i);
    exp_q.delete();
    exp_sof();
    exp_sym(tbl[i].p0); exp_sym(tbl[i].p1); exp_sym(tbl[i].p2); exp_sym(tbl[i].p3);
    exp_eof();
    snd_d.delete(); snd_l.delete();
    snd_d.push_back(tbl[i].data); snd_l.push_back(tbl[i].last);
    fork
      drive_seq(1'b0);
      capture();
    join
    cmp_levels($sformatf("vec%0d", i));
    chk("vec_busy_cycles", cap_busy, 704);
    chk("vec_slot_shape", cap_shape, 0);
    chk("vec_underrun_count", cap_uf, tbl[i].last ? 0 : 1);
    if (!tbl[i].last) begin
      chk("underrun_at_cycle", cap_uf_at, 640);
      chk("busy_fall_after_underrun", cap_busy - cap_uf_at, 64);
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_vld = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    tbl[0] = '{8'hE4, 1'b1, 1, 3, 5, 7};
    tbl[1] = '{8'h1B, 1'b1, 7, 5, 3, 1};
    tbl[2] = '{8'h4E, 1'b1, 5, 7, 1, 3};
    tbl[3] = '{8'h93, 1'b1, 7, 1, 3, 5};
    tbl[4] = '{8'h00, 1'b1, 1, 1, 1, 1};
    tbl[5] = '{8'hFF, 1'b1, 7, 7, 7, 7};
    tbl[6] = '{8'h1B, 1'b0, 7, 5, 3, 1};

    repeat (3) @(negedge clk);
    chk("reset_dout", int'(Dout), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rdy", int'(tx_rdy), 0);
    chk("reset_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    #1 chk("rdy_before_first_edge", int'(tx_rdy), 0);
    @(negedge clk);
    chk("rdy_after_first_edge", int'(tx_rdy), 1);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Two bytes back to back inside one frame.
    exp_q.delete();
    exp_sof();
    for (int k = 0; k < 4; k++) exp_sym(1);
    for (int k = 0; k < 4; k++) exp_sym(7);
    exp_eof();
    snd_d.delete(); snd_l.delete();
    snd_d.push_back(8'h00); snd_l.push_back(1'b0);
    snd_d.push_back(8'hFF); snd_l.push_back(1'b1);
    fork
      drive_seq(1'b0);
      capture();
    join
    cmp_levels("b2b");
    chk("b2b_busy_cycles", cap_busy, 1216);
    chk("b2b_underrun", cap_uf, 0);

    // 16-byte frame with tx_vld held high; decoded back to bytes from the captured line.
    snd_d.delete(); snd_l.delete();
    for (int i = 0; i < 16; i++) begin
      snd_d.push_back(8'(i * 37 + 5));
      snd_l.push_back(i == 15);
    end
    fork
      drive_seq(1'b1);
      capture();
    join
    chk("long_busy_cycles", cap_busy, 8384);
    chk("long_underrun", cap_uf, 0);
    chk("long_slots", lv_q.size(), 8 + 16 * 32 + 4);
    if (lv_q.size() == 8 + 16 * 32 + 4) begin
      int idx;
      idx = 8;
      for (int b = 0; b < 16; b++) begin
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < 4; k++) begin
          int p, lows;
          p = -1; lows = 0;
          for (int s = 0; s < 8; s++) if (lv_q[idx + s] === 1'b0) begin p = s; lows++; end
          if (lows == 1 && (p % 2) == 1) v[2 * k +: 2] = 2'((p - 1) / 2);
          else v = 8'hXX;
          idx += 8;
        end
        chk($sformatf("decoded_byte%0d", b), int'(v), int'(snd_d[b]));
      end
    end

    // Next frame's byte loaded during EOF: frames must abut with no idle cycle.
    exp_q.delete();
    exp_sof(); exp_sym(1); exp_sym(3); exp_sym(5); exp_sym(7); exp_eof();
    exp_sof(); exp_sym(7); exp_sym(5); exp_sym(3); exp_sym(1); exp_eof();
    fork
      begin
        snd_d.delete(); snd_l.delete();
        snd_d.push_back(8'hE4); snd_l.push_back(1'b1);
        drive_seq(1'b0);
        repeat (648) @(negedge clk);
        snd_d.delete(); snd_l.delete();
        snd_d.push_back(8'h1B); snd_l.push_back(1'b1);
        drive_seq(1'b0);
      end
      capture();
    join
    cmp_levels("eof_load");
    chk("eof_load_busy_cycles", cap_busy, 1408);

    // Reset in the middle of a data pulse.
    snd_d.delete(); snd_l.delete();
    snd_d.push_back(8'h4E); snd_l.push_back(1'b1);
    drive_seq(1'b0);
    begin
      int w;
      w = 0;
      while (!busy && w < 100) begin @(negedge clk); w++; end
      repeat (130) @(negedge clk);
      w = 0;
      while (Dout && w < 200) begin @(negedge clk); w++; end
      chk("pulse_before_reset", int'(Dout), 0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_dout", int'(Dout), 1);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_rdy", int'(tx_rdy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset_release", int'(tx_rdy), 1);
    chk("no_frame_after_reset", int'(busy), 0);
    run_vec(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
